// File: rtl/memory_unit_queued.sv
// In-order queued load/store memory: LATENCY edges from engine start to resp_valid (bypass when idle and empty).
// Backpressure: req_ready drops when the queue is full or flush is high; a held response stalls the engine and the queue fills behind it.
module memory_unit_queued #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          MEM_DEPTH   = 1024,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          LATENCY     = 2,
  parameter int          TAG_WIDTH   = 5,
  parameter int          PRESET_ADDR = 6,
  parameter logic [31:0] PRESET_DATA = 32'hFEEDBEEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_is_store,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [TAG_WIDTH-1:0]           req_tag,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_is_store,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic [TAG_WIDTH-1:0]           resp_tag,
  output logic                           resp_err,
  input  logic                           flush,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH:0] MEM_DEPTH_EXT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [PTR_W:0]      QUEUE_FULL    = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;

  logic [ADDR_WIDTH-1:0]  r_q_addr  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]  r_q_wdata [QUEUE_DEPTH];
  logic [TAG_WIDTH-1:0]   r_q_tag   [QUEUE_DEPTH];
  logic                   r_q_store [QUEUE_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]         r_count;

  logic [ADDR_WIDTH-1:0]  r_cur_addr;
  logic [DATA_WIDTH-1:0]  r_cur_wdata;
  logic [TAG_WIDTH-1:0]   r_cur_tag;
  logic                   r_cur_store;

  logic [DATA_WIDTH-1:0]  r_resp_data;
  logic [TAG_WIDTH-1:0]   r_resp_tag;
  logic                   r_resp_err;
  logic                   r_resp_store;

  logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

  logic                   w_accept, w_enq, w_pop, w_bypass, w_load_cur, w_access, w_err;
  logic [IDX_W-1:0]       w_idx;
  logic [ADDR_WIDTH-1:0]  w_cur_addr;
  logic [DATA_WIDTH-1:0]  w_cur_wdata;
  logic [TAG_WIDTH-1:0]   w_cur_tag;
  logic                   w_cur_store;

  assign req_ready     = (r_count < QUEUE_FULL) && !flush;
  assign w_accept      = req_valid && req_ready;
  assign w_enq         = w_accept && !w_bypass;
  assign w_access      = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));
  assign w_err         = {1'b0, r_cur_addr} >= MEM_DEPTH_EXT;
  assign w_idx         = r_cur_addr[IDX_W-1:0];

  assign resp_valid    = (r_state == S_RESP);
  assign resp_data     = r_resp_data;
  assign resp_tag      = r_resp_tag;
  assign resp_err      = r_resp_err;
  assign resp_is_store = r_resp_store;
  assign busy          = (r_count != '0) || (r_state != S_IDLE);
  assign queue_count   = r_count;

  // Next request comes from the queue head, or straight from the port when idle and empty.
  assign w_cur_addr  = w_bypass ? req_addr     : r_q_addr[r_rd_ptr];
  assign w_cur_wdata = w_bypass ? req_wdata    : r_q_wdata[r_rd_ptr];
  assign w_cur_tag   = w_bypass ? req_tag      : r_q_tag[r_rd_ptr];
  assign w_cur_store = w_bypass ? req_is_store : r_q_store[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_bypass    = 1'b0;
    w_load_cur  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush && (r_count != '0)) begin
          w_pop       = 1'b1;
          w_load_cur  = 1'b1;
          w_state_nxt = S_WAIT;
        end else if (w_accept) begin
          w_bypass    = 1'b1;
          w_load_cur  = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          if (!flush && (r_count != '0)) begin
            w_pop       = 1'b1;
            w_load_cur  = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_cur_addr   <= '0;
      r_cur_wdata  <= '0;
      r_cur_tag    <= '0;
      r_cur_store  <= 1'b0;
      r_resp_data  <= '0;
      r_resp_tag   <= '0;
      r_resp_err   <= 1'b0;
      r_resp_store <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_cur) begin
        r_cur_addr  <= w_cur_addr;
        r_cur_wdata <= w_cur_wdata;
        r_cur_tag   <= w_cur_tag;
        r_cur_store <= w_cur_store;
        r_cnt       <= CNT_W'(LATENCY);
      end else if ((r_state == S_WAIT) && (r_cnt != CNT_W'(1))) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_access) begin
        r_resp_tag   <= r_cur_tag;
        r_resp_store <= r_cur_store;
        r_resp_err   <= w_err;
        r_resp_data  <= (r_cur_store || w_err) ? '0 : r_mem[w_idx];
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + (PTR_W + 1)'(w_enq) - (PTR_W + 1)'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_addr[r_wr_ptr]  <= req_addr;
      r_q_wdata[r_wr_ptr] <= req_wdata;
      r_q_tag[r_wr_ptr]   <= req_tag;
      r_q_store[r_wr_ptr] <= req_is_store;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      r_mem[PRESET_ADDR] <= DATA_WIDTH'(PRESET_DATA);
    end else if (w_access && r_cur_store && !w_err) begin
      r_mem[w_idx] <= r_cur_wdata;
    end
  end

endmodule

// File: tb/tb_memory_unit_queued.sv
// Scoreboard bench for memory_unit_queued: directed requests push expected responses, a negedge monitor checks them.
module tb_memory_unit_queued;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        resp_valid, resp_ready, resp_is_store, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        flush, busy;
  logic [2:0]  queue_count;

  typedef struct {
    logic [4:0]  tag;
    logic        st;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  memory_unit_queued dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_store(resp_is_store),
    .resp_data(resp_data), .resp_tag(resp_tag), .resp_err(resp_err),
    .flush(flush), .busy(busy), .queue_count(queue_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // The handshake completes on the posedge following this negedge.
  always @(negedge clk) begin
    if (reset === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got tag %0d data %h, expected no response", resp_tag, resp_data);
      end else begin
        mon_e = sb.pop_front();
        if (resp_tag !== mon_e.tag || resp_is_store !== mon_e.st ||
            resp_data !== mon_e.data || resp_err !== mon_e.err) begin
          errors++;
          $display("FAIL resp: got tag %0d st %b data %h err %b, expected tag %0d st %b data %h err %b",
                   resp_tag, resp_is_store, resp_data, resp_err,
                   mon_e.tag, mon_e.st, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic send(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] tag, input logic [31:0] ed, input logic ee, input bit push);
    int n;
    req_valid = 1'b1; req_is_store = st; req_addr = addr; req_wdata = wd; req_tag = tag;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("send_accept_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (push) sb.push_back('{tag, st, ed, ee});
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(name, {31'b0, done}, 32'd1);
  endtask

  task automatic cycle;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0;
    req_wdata = '0; req_tag = '0; resp_ready = 1'b0; flush = 1'b0;
    #23;
    check("rst_req_ready",   {31'b0, req_ready},     32'd1);
    check("rst_resp_valid",  {31'b0, resp_valid},    32'd0);
    check("rst_busy",        {31'b0, busy},          32'd0);
    check("rst_queue_count", {29'b0, queue_count},   32'd0);
    check("rst_resp_data",   resp_data,              32'd0);
    check("rst_resp_tag",    {27'b0, resp_tag},      32'd0);
    check("rst_resp_err",    {31'b0, resp_err},      32'd0);
    check("rst_resp_store",  {31'b0, resp_is_store}, 32'd0);
    @(negedge clk); reset = 1'b1;
    cycle();

    // Latency from an idle, empty unit: accepted at edge A, valid after A+2.
    send(1'b0, 32'd6, 32'd0, 5'd3, 32'hFEEDBEEF, 1'b0, 1'b1);
    cycle();
    check("lat_a_plus_1_valid", {31'b0, resp_valid}, 32'd0);
    cycle();
    check("lat_a_plus_2_valid", {31'b0, resp_valid}, 32'd1);
    resp_ready = 1'b1;
    drain("drain_preset_load");

    send(1'b1, 32'd10, 32'h12345678, 5'd1, 32'd0, 1'b0, 1'b1);
    send(1'b0, 32'd10, 32'd0,        5'd2, 32'h12345678, 1'b0, 1'b1);
    drain("drain_store_load");

    // One in the engine plus four queued; the write pointer wraps.
    resp_ready = 1'b0;
    send(1'b1, 32'd20, 32'hA5A50001, 5'd4, 32'd0,        1'b0, 1'b1);
    send(1'b0, 32'd20, 32'd0,        5'd5, 32'hA5A50001, 1'b0, 1'b1);
    send(1'b0, 32'd6,  32'd0,        5'd6, 32'hFEEDBEEF, 1'b0, 1'b1);
    send(1'b1, 32'd21, 32'h0BADF00D, 5'd7, 32'd0,        1'b0, 1'b1);
    send(1'b0, 32'd21, 32'd0,        5'd8, 32'h0BADF00D, 1'b0, 1'b1);
    check("full_queue_count", {29'b0, queue_count}, 32'd4);
    check("full_req_ready",   {31'b0, req_ready},   32'd0);
    check("full_busy",        {31'b0, busy},        32'd1);
    resp_ready = 1'b1;
    drain("drain_full_queue");

    send(1'b0, 32'd1024, 32'd0,        5'd9,  32'd0, 1'b1, 1'b1);
    send(1'b1, 32'd1024, 32'hDEADDEAD, 5'd10, 32'd0, 1'b1, 1'b1);
    send(1'b0, 32'd0,    32'd0,        5'd11, 32'd0, 1'b0, 1'b1);
    drain("drain_out_of_range");

    // Flush with three queued and one in flight: only the in-flight one returns.
    resp_ready = 1'b0;
    send(1'b0, 32'd10, 32'd0, 5'd14, 32'h12345678, 1'b0, 1'b1);
    send(1'b0, 32'd6,  32'd0, 5'd15, 32'd0, 1'b0, 1'b0);
    send(1'b0, 32'd6,  32'd0, 5'd16, 32'd0, 1'b0, 1'b0);
    send(1'b0, 32'd6,  32'd0, 5'd17, 32'd0, 1'b0, 1'b0);
    check("flush_pre_count", {29'b0, queue_count}, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid) begin seen = 1'b1; break; end
      cycle();
    end
    check("flush_resp_pending", {31'b0, seen}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_count",     {29'b0, queue_count}, 32'd0);
    check("flush_busy_held", {31'b0, busy},        32'd1);
    resp_ready = 1'b1;
    cycle();
    check("flush_busy_drop", {31'b0, busy},        32'd0);
    repeat (6) cycle();
    check("flush_sb_empty",  sb.size(),            32'd0);

    // Reset while a request is in WAIT and another is queued.
    send(1'b0, 32'd6, 32'd0, 5'd12, 32'd0, 1'b0, 1'b0);
    send(1'b1, 32'd6, 32'h11111111, 5'd13, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_resp_valid",  {31'b0, resp_valid},   32'd0);
    check("midrst_req_ready",   {31'b0, req_ready},    32'd1);
    check("midrst_busy",        {31'b0, busy},         32'd0);
    check("midrst_queue_count", {29'b0, queue_count},  32'd0);
    check("midrst_resp_tag",    {27'b0, resp_tag},     32'd0);
    check("midrst_resp_data",   resp_data,             32'd0);
    repeat (2) cycle();
    @(negedge clk); reset = 1'b1;
    repeat (6) cycle();
    check("midrst_no_resp", {31'b0, resp_valid}, 32'd0);
    send(1'b0, 32'd6,  32'd0, 5'd18, 32'hFEEDBEEF, 1'b0, 1'b1);
    send(1'b0, 32'd10, 32'd0, 5'd19, 32'd0,        1'b0, 1'b1);
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
